prco_mem_ctrl: RTL and testbench

//   Requester side of the local-memory port. Accepts instruction-fetch requests (fetch stage)
//   and load/store requests (ALU stage), arbitrates them onto the single memory port, drives
//   the one-cycle ce_fetch/ce_alu strobes, waits for the matching ce_dec/ce_reg completion

---
 rtl/prco_mem_ctrl.sv | 124 ++++++++++++
 tb/tb_prco_mem_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prco_mem_ctrl.sv
// prco_mem_ctrl: arbitrates fetch and load/store requests onto the single local-memory port,
// waits for the matching completion strobe (with timeout) and returns the read word.
module prco_mem_ctrl #(
    parameter int          P_TIMEOUT   = 15,
    parameter int          P_CNT_WIDTH = 4,
    parameter logic [15:0] P_ERR_WORD  = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_fetch_req,
    input  logic [15:0] i_fetch_addr,
    output logic        q_fetch_valid,
    output logic [15:0] q_fetch_instr,
    input  logic        i_data_req,
    input  logic        i_data_we,
    input  logic [15:0] i_data_addr,
    input  logic [15:0] i_data_wdata,
    output logic        q_data_done,
    output logic [15:0] q_data_rdata,
    output logic        q_busy,
    output logic        q_err,
    output logic        q_ce_fetch,
    output logic        q_ce_alu,
    output logic        q_mem_we,
    output logic [15:0] q_mem_addr,
    output logic [15:0] q_mem_dina,
    input  logic        i_ce_dec,
    input  logic        i_ce_reg,
    input  logic [15:0] i_mem_douta
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_F, S_WAIT_D, S_RESP} state_t;

    state_t                 r_state, w_state_nx;
    logic [P_CNT_WIDTH-1:0] r_cnt, w_cnt_nx;
    logic                   w_data, w_hit, w_miss, w_expire;
    logic                   w_ce_fetch, w_ce_alu, w_we, w_fvalid, w_done, w_err;
    logic [15:0]            w_addr, w_dina, w_finstr, w_rdata;

    assign w_data   = (r_state == S_WAIT_D);
    assign w_hit    = w_data ? i_ce_reg : i_ce_dec;
    assign w_miss   = w_data ? i_ce_dec : i_ce_reg;
    assign w_expire = (r_cnt == P_CNT_WIDTH'(P_TIMEOUT - 1));

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_ce_fetch = 1'b0;
        w_ce_alu   = 1'b0;
        w_we       = 1'b0;
        w_fvalid   = 1'b0;
        w_done     = 1'b0;
        w_addr     = q_mem_addr;
        w_dina     = q_mem_dina;
        w_finstr   = q_fetch_instr;
        w_rdata    = q_data_rdata;
        w_err      = q_err;
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (i_data_req) begin
                    w_state_nx = S_WAIT_D;
                    w_ce_alu   = 1'b1;
                    w_we       = i_data_we;
                    w_addr     = i_data_addr;
                    w_dina     = i_data_wdata;
                end else if (i_fetch_req) begin
                    w_state_nx = S_WAIT_F;
                    w_ce_fetch = 1'b1;
                    w_addr     = i_fetch_addr;
                end
            end
            S_WAIT_F, S_WAIT_D: begin
                // a matching strobe beats both a simultaneous mismatch and the timeout
                if (w_hit || w_expire) begin
                    w_state_nx = S_RESP;
                    w_err      = q_err | ~w_hit;
                    if (w_data) begin
                        w_done  = 1'b1;
                        w_rdata = w_hit ? i_mem_douta : P_ERR_WORD;
                    end else begin
                        w_fvalid = 1'b1;
                        w_finstr = w_hit ? i_mem_douta : P_ERR_WORD;
                    end
                end else begin
                    w_err    = q_err | w_miss;
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            q_ce_fetch    <= 1'b0;
            q_ce_alu      <= 1'b0;
            q_mem_we      <= 1'b0;
            q_mem_addr    <= '0;
            q_mem_dina    <= '0;
            q_fetch_valid <= 1'b0;
            q_fetch_instr <= '0;
            q_data_done   <= 1'b0;
            q_data_rdata  <= '0;
            q_busy        <= 1'b0;
            q_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            q_ce_fetch    <= w_ce_fetch;
            q_ce_alu      <= w_ce_alu;
            q_mem_we      <= w_we;
            q_mem_addr    <= w_addr;
            q_mem_dina    <= w_dina;
            q_fetch_valid <= w_fvalid;
            q_fetch_instr <= w_finstr;
            q_data_done   <= w_done;
            q_data_rdata  <= w_rdata;
            q_busy        <= (w_state_nx != S_IDLE);
            q_err         <= w_err;
        end
    end
endmodule

// File: tb/tb_prco_mem_ctrl.sv
// tb_prco_mem_ctrl: directed requests against a memory responder, with a cycle-timeline
// model of when strobes, completions and errors must appear.
module tb_prco_mem_ctrl;
    localparam int TO = 15;

    logic        i_clk = 1'b0, i_reset = 1'b0;
    logic        i_fetch_req = 1'b0, i_data_req = 1'b0, i_data_we = 1'b0;
    logic [15:0] i_fetch_addr = '0, i_data_addr = '0, i_data_wdata = '0;
    logic        i_ce_dec = 1'b0, i_ce_reg = 1'b0;
    logic [15:0] i_mem_douta = '0;
    logic        q_fetch_valid, q_data_done, q_busy, q_err, q_ce_fetch, q_ce_alu, q_mem_we;
    logic [15:0] q_fetch_instr, q_data_rdata, q_mem_addr, q_mem_dina;

    prco_mem_ctrl dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
        .q_fetch_valid(q_fetch_valid), .q_fetch_instr(q_fetch_instr),
        .i_data_req(i_data_req), .i_data_we(i_data_we), .i_data_addr(i_data_addr),
        .i_data_wdata(i_data_wdata), .q_data_done(q_data_done), .q_data_rdata(q_data_rdata),
        .q_busy(q_busy), .q_err(q_err), .q_ce_fetch(q_ce_fetch), .q_ce_alu(q_ce_alu),
        .q_mem_we(q_mem_we), .q_mem_addr(q_mem_addr), .q_mem_dina(q_mem_dina),
        .i_ce_dec(i_ce_dec), .i_ce_reg(i_ce_reg), .i_mem_douta(i_mem_douta)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // memory responder: answers a strobe resp_delay cycles later, optionally injects a stray ce_reg
    logic [15:0] mem [0:255];
    int          resp_delay = 1, inj_delay = 0, cnt = 0, inj_cnt = 0;
    bit          silent = 0, pk = 0;
    logic [15:0] pdata = '0;

    initial begin
        forever begin
            @(posedge i_clk); #1;
            i_ce_reg = 1'b0;
            i_ce_dec = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !silent) begin
                    if (pk) i_ce_reg = 1'b1; else i_ce_dec = 1'b1;
                    i_mem_douta = pdata;
                end
            end
            if (inj_cnt > 0) begin
                inj_cnt--;
                if (inj_cnt == 0) i_ce_reg = 1'b1;
            end
            if (q_ce_alu || q_ce_fetch) begin
                pk      = q_ce_alu;
                cnt     = resp_delay;
                inj_cnt = inj_delay;
                pdata   = mem[q_mem_addr[7:0]];
                if (q_ce_alu && q_mem_we) mem[q_mem_addr[7:0]] = q_mem_dina;
            end
        end
    end

    // timeline model: acc = cycle a request was taken, fin = completion seen (response next cycle)
    int          cyc = 0, acc = -1;
    bit          fin = 0, kd = 0;
    logic        e_ce_fetch = 0, e_ce_alu = 0, e_we = 0, e_fvalid = 0, e_done = 0, e_busy = 0, e_err = 0;
    logic [15:0] e_addr = '0, e_dina = '0, e_finstr = '0, e_rdata = '0;
    int          n_cef = 0, n_we = 0, n_busy = 0, n_done = 0;

    always @(negedge i_clk) begin
        cyc++;
        if (!i_reset) begin
            acc = -1; fin = 0;
            {e_ce_fetch, e_ce_alu, e_we, e_fvalid, e_done, e_busy, e_err} = '0;
            {e_addr, e_dina, e_finstr, e_rdata} = '0;
        end
        chk("m_ce_fetch", 16'(q_ce_fetch), 16'(e_ce_fetch));
        chk("m_ce_alu", 16'(q_ce_alu), 16'(e_ce_alu));
        chk("m_we", 16'(q_mem_we), 16'(e_we));
        chk("m_fvalid", 16'(q_fetch_valid), 16'(e_fvalid));
        chk("m_done", 16'(q_data_done), 16'(e_done));
        chk("m_busy", 16'(q_busy), 16'(e_busy));
        chk("m_err", 16'(q_err), 16'(e_err));
        chk("m_finstr", q_fetch_instr, e_finstr);
        chk("m_rdata", q_data_rdata, e_rdata);
        chk("m_excl", 16'(q_ce_fetch & q_ce_alu), 16'd0);
        if (q_ce_alu || q_ce_fetch) begin
            chk("m_addr", q_mem_addr, e_addr);
            if (q_ce_alu) chk("m_dina", q_mem_dina, e_dina);
        end
        if (q_ce_fetch) n_cef++;
        if (q_mem_we) n_we++;
        if (q_busy) n_busy++;
        if (q_data_done) n_done++;
        if (i_reset) begin
            {e_ce_fetch, e_ce_alu, e_we, e_fvalid, e_done} = '0;
            if (acc < 0) begin
                if (i_data_req) begin
                    acc = cyc; kd = 1; e_ce_alu = 1; e_we = i_data_we;
                    e_addr = i_data_addr; e_dina = i_data_wdata;
                end else if (i_fetch_req) begin
                    acc = cyc; kd = 0; e_ce_fetch = 1; e_addr = i_fetch_addr;
                end
            end else if (!fin) begin
                if (kd ? i_ce_reg : i_ce_dec) begin
                    fin = 1;
                    if (kd) begin e_done = 1; e_rdata = i_mem_douta; end
                    else begin e_fvalid = 1; e_finstr = i_mem_douta; end
                end else begin
                    if (kd ? i_ce_dec : i_ce_reg) e_err = 1;
                    if (cyc - acc == TO) begin
                        fin = 1; e_err = 1;
                        if (kd) begin e_done = 1; e_rdata = 16'h0000; end
                        else begin e_fvalid = 1; e_finstr = 16'h0000; end
                    end
                end
            end else begin
                acc = -1; fin = 0;
            end
            e_busy = (acc >= 0);
        end
    end

    task automatic do_fetch(input logic [15:0] a, output logic [15:0] d, output int lat);
        i_fetch_addr = a; i_fetch_req = 1'b1; lat = 0; d = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge i_clk); #1;
            if (q_fetch_valid) begin lat = k; d = q_fetch_instr; break; end
        end
        if (lat == 0) chk("fetch_wait_expired", 16'd0, 16'd1);
        @(posedge i_clk); #1;
        i_fetch_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [15:0] a, input logic [15:0] wd,
                           output logic [15:0] d, output int lat);
        i_data_we = we; i_data_addr = a; i_data_wdata = wd; i_data_req = 1'b1; lat = 0; d = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge i_clk); #1;
            if (q_data_done) begin lat = k; d = q_data_rdata; break; end
        end
        if (lat == 0) chk("data_wait_expired", 16'd0, 16'd1);
        @(posedge i_clk); #1;
        i_data_req = 1'b0;
    endtask

    logic [15:0] d, d2;
    int          lat, lat2, c0, b0, w0, dn0;

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 16'h1000 + 16'(k);
        mem[0]     = 16'h20AB;
        mem[8'hAA] = 16'h1234;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_flags", 16'({q_fetch_valid, q_data_done, q_busy, q_err, q_ce_fetch, q_ce_alu, q_mem_we}), 16'd0);
        chk("rst_instr", q_fetch_instr, 16'h0000);
        chk("rst_rdata", q_data_rdata, 16'h0000);
        i_reset = 1'b1;
        @(posedge i_clk); #1;

        c0 = n_cef; b0 = n_busy;
        do_fetch(16'h0000, d, lat);
        chk("t1_instr", d, 16'h20AB);
        chk("t1_lat", 16'(lat), 16'd3);
        chk("t1_ce_fetch_cycles", 16'(n_cef - c0), 16'd1);
        chk("t1_busy_cycles", 16'(n_busy - b0), 16'd3);

        w0 = n_we;
        do_data(1'b1, 16'h00AA, 16'hBEEF, d, lat);
        chk("t2_store_old", d, 16'h1234);
        chk("t2_we_store", 16'(n_we - w0), 16'd1);
        do_data(1'b0, 16'h00AA, 16'h0000, d, lat);
        chk("t2_load", d, 16'hBEEF);
        chk("t2_we_total", 16'(n_we - w0), 16'd1);
        chk("t2_err", 16'(q_err), 16'd0);

        fork
            do_data(1'b0, 16'h0005, 16'h0000, d, lat);
            do_fetch(16'h0000, d2, lat2);
        join
        chk("t3_data", d, 16'h1005);
        chk("t3_data_lat", 16'(lat), 16'd3);
        chk("t3_fetch", d2, 16'h20AB);
        chk("t3_fetch_lat", 16'(lat2), 16'd7);

        resp_delay = 4; inj_delay = 2;
        do_fetch(16'h0000, d, lat);
        resp_delay = 1; inj_delay = 0;
        chk("t5_instr", d, 16'h20AB);
        chk("t5_lat", 16'(lat), 16'd6);
        chk("t5_err", 16'(q_err), 16'd1);

        i_reset = 1'b0;
        @(posedge i_clk); #1;
        chk("rst2_err", 16'(q_err), 16'd0);
        i_reset = 1'b1;
        @(posedge i_clk); #1;

        silent = 1;
        do_data(1'b0, 16'h0010, 16'h0000, d, lat);
        silent = 0;
        chk("t4_rdata", d, 16'h0000);
        chk("t4_lat", 16'(lat), 16'(TO + 1));
        chk("t4_err", 16'(q_err), 16'd1);
        do_fetch(16'h0000, d, lat);
        chk("t4_fetch_after", d, 16'h20AB);
        do_data(1'b0, 16'h00AA, 16'h0000, d, lat);
        chk("t4_load_after", d, 16'hBEEF);
        chk("t4_err_sticky", 16'(q_err), 16'd1);

        resp_delay = 3; dn0 = n_done;
        i_data_we = 1'b0; i_data_addr = 16'h00AA; i_data_req = 1'b1;
        @(posedge i_clk); #1;
        @(posedge i_clk); #3;
        i_reset = 1'b0;
        #1;
        chk("t6_flags", 16'({q_fetch_valid, q_data_done, q_busy, q_err, q_ce_fetch, q_ce_alu, q_mem_we}), 16'd0);
        chk("t6_rdata", q_data_rdata, 16'h0000);
        chk("t6_instr", q_fetch_instr, 16'h0000);
        chk("t6_addr", q_mem_addr, 16'h0000);
        i_data_req = 1'b0;
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        resp_delay = 1;
        repeat (6) @(posedge i_clk);
        #1;
        chk("t6_no_done", 16'(n_done - dn0), 16'd0);
        chk("t6_err_after", 16'(q_err), 16'd0);
        chk("t6_busy_after", 16'(q_busy), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
